led_src_arbiter: RTL and testbench

LED_SRC_ARBITER -- requirements
Module: led_src_arbiter

---
 rtl/led_arb_pkg.sv | 18 +
 rtl/dwell_timer.sv | 42 ++++
 rtl/led_src_arbiter.sv | 121 ++++++++++++
 tb/tb_led_src_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and defaults for the two-source LED arbiter.
package led_arb_pkg;

  localparam int unsigned LED_N_DEF = 4;
  localparam int unsigned DWELL_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  // Dwell counter width: clog2(DWELL), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that measures how long the current owner keeps the LEDs.
// Load sets it to DWELL-1; decrement stops at zero; o_zero flags "dwell over".
module dwell_timer
  import led_arb_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEF,
  localparam int unsigned CW   = cnt_width(DWELL)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/led_src_arbiter.sv
// Arbitrates two LED sources with a non-preemptible minimum dwell per grant.
//
// Handshake: i_req_x is a level request; a grant is the one-cycle pulse
// o_gnt_x in the first cycle of a new dwell. Requests are only looked at
// when the FSM is idle or the dwell counter reads zero; at all other times
// they are ignored. There is no ready/backpressure toward the sources.
module led_src_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned N     = LED_N_DEF,
  parameter int unsigned DWELL = DWELL_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req_a,
  input  logic [N-1:0] i_a,
  input  logic         i_req_b,
  input  logic [N-1:0] i_b,
  output logic         o_gnt_a,
  output logic         o_gnt_b,
  output logic         o_sel,
  output logic [N-1:0] o_y,
  output logic         o_busy,
  output state_t       o_dbg_state
);

  state_t       state_q, state_d;
  logic         last_b_q, last_b_d;
  logic         sel_q, sel_d;
  logic [N-1:0] y_q, y_d;
  logic         gnt_a_q, gnt_a_d;
  logic         gnt_b_q, gnt_b_d;
  logic         tmr_load;
  logic         tmr_dec;
  logic         tmr_zero;
  logic         arb_ok;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (tmr_load),
    .i_dec   (tmr_dec),
    .o_zero  (tmr_zero)
  );

  // Next-state, grant and output-register inputs.
  // A tie goes to the source not served last. While showing x, last_b
  // already names x, so the same test also gives "other source first"
  // at the end of a dwell, and a lone request re-grants its own source.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    sel_d    = sel_q;
    y_d      = '0;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    arb_ok   = (state_q == IDLE) || tmr_zero;

    if (arb_ok) begin
      if (i_req_a && (!i_req_b || last_b_q)) begin
        state_d  = SHOW_A;
        gnt_a_d  = 1'b1;
        last_b_d = 1'b0;
        tmr_load = 1'b1;
      end else if (i_req_b) begin
        state_d  = SHOW_B;
        gnt_b_d  = 1'b1;
        last_b_d = 1'b1;
        tmr_load = 1'b1;
      end else begin
        state_d  = IDLE;
      end
    end else begin
      tmr_dec = 1'b1;
    end

    // LED data and select follow the owner we are about to be in.
    case (state_d)
      SHOW_A: begin
        sel_d = 1'b0;
        y_d   = i_a;
      end
      SHOW_B: begin
        sel_d = 1'b1;
        y_d   = i_b;
      end
      default: begin
        y_d = '0;
      end
    endcase
  end

  // State and output registers; reset makes A win the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      sel_q    <= 1'b0;
      y_q      <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
      y_q      <= y_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
    end
  end

  assign o_gnt_a     = gnt_a_q;
  assign o_gnt_b     = gnt_b_q;
  assign o_sel       = sel_q;
  assign o_y         = y_q;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_led_src_arbiter.sv
// Bench for led_src_arbiter: DWELL=4 instance plus a DWELL=1 instance.
module tb_led_src_arbiter;
  import led_arb_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DWELL=4 instance
  logic         req_a, req_b;
  logic [N-1:0] a, b;
  logic         gnt_a, gnt_b, sel, busy;
  logic [N-1:0] y;
  state_t       dbg;

  // DWELL=1 instance
  logic         req_a1, req_b1;
  logic [N-1:0] a1, b1;
  logic         gnt_a1, gnt_b1, sel1, busy1;
  logic [N-1:0] y1;
  state_t       dbg1;

  led_src_arbiter #(.N(N), .DWELL(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_a(a), .i_req_b(req_b), .i_b(b),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_sel(sel), .o_y(y),
    .o_busy(busy), .o_dbg_state(dbg)
  );

  led_src_arbiter #(.N(N), .DWELL(1)) dut_d1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a1), .i_a(a1), .i_req_b(req_b1), .i_b(b1),
    .o_gnt_a(gnt_a1), .o_gnt_b(gnt_b1), .o_sel(sel1), .o_y(y1),
    .o_busy(busy1), .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 idle, 0 = A, 1 = B; left = cycles of dwell still to run.
  int           m_owner, m_left, m_last;
  logic [N-1:0] m_y;
  logic         m_sel, m_ga, m_gb;

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_last = 1;
    m_y = '0; m_sel = 1'b0; m_ga = 1'b0; m_gb = 1'b0;
  endtask

  task automatic model_step(input logic ra, input logic rb,
                            input logic [N-1:0] da, input logic [N-1:0] db);
    int pick;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (m_owner >= 0 && m_left > 0) begin
      m_left = m_left - 1;
      m_y = (m_owner == 1) ? db : da;
    end else begin
      pick = -1;
      if (ra && rb)  pick = (m_last == 1) ? 0 : 1;
      else if (ra)   pick = 0;
      else if (rb)   pick = 1;
      if (pick < 0) begin
        m_owner = -1;
        m_y = '0;
      end else begin
        m_owner = pick;
        m_left  = D - 1;
        m_last  = pick;
        m_sel   = (pick == 1);
        m_y     = (pick == 1) ? db : da;
        m_ga    = (pick == 0);
        m_gb    = (pick == 1);
      end
    end
  endtask

  task automatic check_model(input string tag);
    state_t es;
    es = (m_owner < 0) ? IDLE : ((m_owner == 0) ? SHOW_A : SHOW_B);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(m_ga));
    chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(m_gb));
    chk({tag, ".sel"},   32'(sel),   32'(m_sel));
    chk({tag, ".y"},     32'(y),     32'(m_y));
    chk({tag, ".busy"},  32'(busy),  32'(m_owner >= 0));
    chk({tag, ".state"}, 32'(dbg),   32'(es));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ra, input logic [N-1:0] da,
                       input logic rb, input logic [N-1:0] db);
    req_a = ra; a = da; req_b = rb; b = db;
  endtask

  // One rising edge: model sees the same inputs, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step(req_a, req_b, a, b);
    #1;
  endtask

  task automatic do_reset(input bit check_it);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    req_a1 = 1'b0; req_b1 = 1'b0; a1 = '0; b1 = '0;
    @(posedge clk);
    #1;
    if (check_it) begin
      chk("rst.gnt_a", 32'(gnt_a), 0);
      chk("rst.gnt_b", 32'(gnt_b), 0);
      chk("rst.sel",   32'(sel),   0);
      chk("rst.y",     32'(y),     0);
      chk("rst.busy",  32'(busy),  0);
      chk("rst.state", 32'(dbg),   32'(IDLE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         ra;
    logic [N-1:0] da;
    logic         rb;
    logic [N-1:0] db;
    logic         ega;
    logic         egb;
    logic         esel;
    logic [N-1:0] ey;
    logic         ebusy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Both request from reset (rows 0..11 are cycles 1..12), then drop, then B alone.
    tbl[0]  = '{1, 4'h3, 1, 4'hC, 1, 0, 0, 4'h3, 1};
    tbl[1]  = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[2]  = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[3]  = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[4]  = '{1, 4'h3, 1, 4'hC, 0, 1, 1, 4'hC, 1};
    tbl[5]  = '{1, 4'h3, 1, 4'hC, 0, 0, 1, 4'hC, 1};
    tbl[6]  = '{1, 4'h3, 1, 4'hC, 0, 0, 1, 4'hC, 1};
    tbl[7]  = '{1, 4'h3, 1, 4'hC, 0, 0, 1, 4'hC, 1};
    tbl[8]  = '{1, 4'h3, 1, 4'hC, 1, 0, 0, 4'h3, 1};
    tbl[9]  = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[10] = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[11] = '{1, 4'h3, 1, 4'hC, 0, 0, 0, 4'h3, 1};
    tbl[12] = '{0, 4'h3, 0, 4'hC, 0, 0, 0, 4'h0, 0};
    tbl[13] = '{0, 4'h3, 1, 4'h5, 0, 1, 1, 4'h5, 1};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    req_a1 = 1'b0; req_b1 = 1'b0; a1 = '0; b1 = '0;
    model_reset();

    // Reset state.
    do_reset(1'b1);

    // Table: alternating ownership under constant contention, idle, lone B.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db);
      step();
      chk($sformatf("tbl%0d.gnt_a", i), 32'(gnt_a), 32'(tbl[i].ega));
      chk($sformatf("tbl%0d.gnt_b", i), 32'(gnt_b), 32'(tbl[i].egb));
      chk($sformatf("tbl%0d.sel", i),   32'(sel),   32'(tbl[i].esel));
      chk($sformatf("tbl%0d.y", i),     32'(y),     32'(tbl[i].ey));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),  32'(tbl[i].ebusy));
      chk($sformatf("tbl%0d.excl", i),  32'(gnt_a & gnt_b), 0);
    end

    // Only A requests for 10 cycles: re-grants at 1, 5, 9.
    do_reset(1'b0);
    drive(1'b1, 4'hA, 1'b0, 4'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("onlyA%0d.gnt_a", c), 32'(gnt_a), 32'(c == 1 || c == 5 || c == 9));
      chk($sformatf("onlyA%0d.sel", c),   32'(sel),  0);
      chk($sformatf("onlyA%0d.y", c),     32'(y),    32'h A);
      chk($sformatf("onlyA%0d.busy", c),  32'(busy), 1);
    end

    // A granted at 1, B raises at 2: B must wait for the dwell to end.
    do_reset(1'b0);
    drive(1'b1, 4'h6, 1'b0, 4'h9);
    for (int c = 1; c <= 6; c++) begin
      step();
      check_model($sformatf("nopre%0d", c));
      chk($sformatf("nopre%0d.gnt_b_exp", c), 32'(gnt_b), 32'(c == 5));
      chk($sformatf("nopre%0d.sel_exp", c),   32'(sel),   32'(c >= 5));
      if (c == 1) drive(1'b1, 4'h6, 1'b1, 4'h9);
    end

    // One-cycle request from A: full dwell, then idle.
    do_reset(1'b0);
    drive(1'b1, 4'h7, 1'b0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check_model($sformatf("pulseA%0d", c));
      chk($sformatf("pulseA%0d.busy_exp", c), 32'(busy), 32'(c <= 4));
      chk($sformatf("pulseA%0d.y_exp", c),    32'(y),    (c <= 4) ? 32'h7 : 32'h0);
      if (c == 1) drive(1'b0, 4'h7, 1'b0, 4'h0);
    end

    // Asynchronous reset in the third cycle of SHOW_B.
    do_reset(1'b0);
    drive(1'b0, 4'h0, 1'b1, 4'h9);
    for (int c = 1; c <= 3; c++) begin
      step();
      check_model($sformatf("arst%0d", c));
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.gnt_b", 32'(gnt_b), 0);
    chk("arst.sel",   32'(sel),   0);
    chk("arst.y",     32'(y),     0);
    chk("arst.busy",  32'(busy),  0);
    drive(1'b1, 4'h3, 1'b1, 4'hC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check_model("arst_rel");
    chk("arst_rel.gnt_a_exp", 32'(gnt_a), 1);

    // DWELL=1 instance: strict alternation under contention.
    do_reset(1'b0);
    req_a1 = 1'b1; a1 = 4'h3; req_b1 = 1'b1; b1 = 4'hC;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("d1_%0d.gnt_a", c), 32'(gnt_a1), 32'(c % 2 == 1));
      chk($sformatf("d1_%0d.gnt_b", c), 32'(gnt_b1), 32'(c % 2 == 0));
      chk($sformatf("d1_%0d.sel", c),   32'(sel1),   32'(c % 2 == 0));
      chk($sformatf("d1_%0d.y", c),     32'(y1),     (c % 2 == 1) ? 32'h3 : 32'hC);
    end

    // Randomized traffic against the reference model, with one reset mid-run.
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      int bias;
      bias = (c / 50) % 4;
      drive($urandom_range(0, 3) < bias + 1, N'($urandom),
            $urandom_range(0, 3) < 3 - bias + 1, N'($urandom));
      if (c == 200) begin
        do_reset(1'b0);
      end else begin
        step();
        check_model($sformatf("rnd%0d", c));
        exp_q.push_back(m_y);
        chk($sformatf("rnd%0d.y_q", c), 32'(y), 32'(exp_q.pop_front()));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
